// File: rtl/argmax_13_32.sv
// rtl/argmax_13_32.sv - streaming argmax over 13-element signed vectors
// Optional macro ARGMAX_TIE_LAST_EN: ties resolve to the highest index instead of the lowest.
module argmax_13_32 #(
  parameter int M  = 13,
  parameter int T  = 32,
  parameter int IW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         input_valid,
  output logic         input_ready,
  input  logic [T-1:0] input_data,
  output logic         output_valid,
  input  logic         output_ready,
  output logic [T-1:0] output_data,
  output logic [T-1:0] output_max
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        cnt;
  logic [IW-1:0]        bidx;
  logic signed [T-1:0]  best;
  logic [IW-1:0]        fold_idx;
  logic signed [T-1:0]  fold_best;
  logic                 take;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last;

  always_comb begin
    input_ready  = (state == COLLECT) && !reset;
    output_valid = (state == HOLD);
    in_fire      = input_valid && input_ready;
    out_fire     = output_valid && output_ready;
    last         = (cnt == IW'(M - 1));
  end

`ifdef ARGMAX_TIE_LAST_EN
  assign take = ($signed(input_data) >= best);
`else
  assign take = ($signed(input_data) > best);
`endif

  // First element of a vector always seeds the running max; cnt is 0 then, so bidx gets 0.
  always_comb begin
    fold_best = best;
    fold_idx  = bidx;
    if (cnt == '0 || take) begin
      fold_best = $signed(input_data);
      fold_idx  = cnt;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (in_fire && last) state_next = HOLD;
      HOLD:    if (out_fire)        state_next = COLLECT;
      default:                      state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      best        <= '0;
      bidx        <= '0;
      output_data <= '0;
      output_max  <= '0;
    end else if (in_fire) begin
      best <= fold_best;
      bidx <= fold_idx;
      if (last) begin
        cnt         <= '0;
        output_data <= {{(T-IW){1'b0}}, fold_idx};
        output_max  <= fold_best;
      end else begin
        cnt <= cnt + IW'(1);
      end
    end
  end

endmodule

// File: doc/argmax_13_32.md
# argmax_13_32

Streaming argmax stage placed directly downstream of `fc_13_16_32_1_1`. It consumes each 13-element signed output vector of the fully-connected layer, one element per handshake, and emits a single result per vector: the index of the largest element and that element's value. Both sides use the same valid/ready protocol as the layer it follows. The bench drives it with the same randomized valid/ready style used for the fc layers.

## Interface
- `M`, 13, elements per vector; must match the upstream layer's output count.
- `T`, 32, data width in bits; elements are two's-complement signed.
- `IW`, 4, index width, equal to $clog2(M).
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `input_valid`  input  1  upstream element available.
- `input_ready`  output  1  block accepts an element this cycle.
- `input_data`  input  T  signed element from the fc layer.
- `output_valid`  output  1  result available.
- `output_ready`  input  1  downstream accepts the result.
- `output_data`  output  T  winning index in bits [IW-1:0], zero-extended to T.
- `output_max`  output  T  signed value of the winning element.

## Operation
- Registers:
  - element counter `cnt` (IW bits, range 0..M-1);
  - running maximum `best` (T bits, signed);
  - running index `bidx` (IW bits);
  - 1-bit state: COLLECT or HOLD.
- COLLECT:
  - `input_ready=1`; an element is accepted when `input_valid && input_ready`.
  - Accept with `cnt==0`: `best<=input_data`, `bidx<=0`.
  - Accept with `cnt>0`: replace `best`/`bidx` with the element and `cnt` when `input_data > best` (signed comparison). Otherwise keep them.
  - Accept with `cnt<M-1`: `cnt<=cnt+1`.
  - Accept with `cnt==M-1`: fold in the element first, then load `output_data`/`output_max` with the final result, set `cnt<=0` and go to HOLD.
- HOLD:
  - `input_ready=0`, `output_valid=1`, outputs held stable.
  - On `output_valid && output_ready`: clear `output_valid` and return to COLLECT.
- Ties: the lowest index wins (strict `>`), unless the macro in Configuration is defined.
- There is no arithmetic beyond signed compare. No overflow is possible.
- `input_data` is ignored whenever the handshake does not complete, including X values.

## Timing
- Reset (`reset` high at a rising edge):
  - state=COLLECT, `cnt=0`, `best=0`, `bidx=0`;
  - `output_valid=0`, `output_data=0`, `output_max=0`.
  - `input_ready` is forced 0 while `reset` is high and is 1 in the first cycle after reset.
- Reset mid-vector or in HOLD discards the partial or pending result. No output is produced for that vector.
- Latency: `output_valid` rises in the cycle after the M-th element's handshake edge.
- Throughput:
  - at best M+1 cycles per vector: M accepts plus 1 HOLD cycle with `output_ready=1`;
  - back-pressure on the output stalls input acceptance.
- `input_ready` and `output_valid` are never both 1 in the same cycle. Combinational paths from `input_valid` or `output_ready` to any output are forbidden.
- Gaps: `input_valid=0` for any number of cycles leaves all state unchanged.
- `output_valid`, once high, stays high with stable data until the handshake completes.

## Configuration
- `ARGMAX_TIE_LAST_EN`:
  - Defined: the compare becomes signed `>=`, so among equal maxima the highest index wins.
  - Undefined (default): strict `>`, lowest index wins.
  - Nothing else changes: interface, latency and reset values are identical.

## Test plan
- Ascending vector 0,1,…,12 with `input_valid` and `output_ready` held 1 → `output_data=12`, `output_max=12`; `output_valid` rises exactly 1 cycle after the 13th accept.
- All elements −5 except element 4 = 7FFFFFFF and element 9 = 80000000 → `output_data=4`, `output_max=0x7FFFFFFF`. This checks that the compare is signed.
- Vector of 13 copies of 0xFFFFFFF6 (−10):
  - default build → `output_data=0`, `output_max=0xFFFFFFF6`;
  - with `ARGMAX_TIE_LAST_EN` → `output_data=12`.
- Randomized `input_valid`/`output_ready` (50% each) over 625 vectors, i.e. 8125 elements, compared against the argmax of the same data computed in the bench → 625 results, 0 errors; `input_ready` is 0 whenever `output_valid` is 1.
- Reset asserted for 1 cycle after 6 elements of vector A, then a full vector B (max 3 at index 2) is sent → exactly one result, `output_data=2`, `output_max=3`.
- Result held with `output_ready=0` for 20 cycles while `input_valid=1` → outputs stable, no elements accepted; release → next vector is accepted starting the following cycle.
